// File: rtl/t9990_cpu_bridge_pkg.sv
// Shared types and VDP port numbers for the T9990 host CPU bridge.
package t9990_cpu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } bridge_state_e;

    localparam logic [3:0] P0_VRAM   = 4'd0;
    localparam logic [3:0] P1_PAL    = 4'd1;
    localparam logic [3:0] P2_CMD    = 4'd2;
    localparam logic [3:0] P3_REG    = 4'd3;
    localparam logic [3:0] P4_REGSEL = 4'd4;
    localparam logic [3:0] P5_STATUS = 4'd5;

endpackage

// File: rtl/t9990_bridge_sync.sv
// N-stage synchroniser for active-low host control lines; flops reset to the idle (1) level.
module t9990_bridge_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
        logic [STAGES-1:0] chain_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                chain_q <= '1;
            end else begin
                chain_q <= STAGES'({chain_q, d_i[gi]});
            end
        end

        assign q_o[gi] = chain_q[STAGES-1];
    end

    // valid_o rises once the chains hold real samples rather than reset values.
    logic [STAGES-1:0] fill_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q <= '0;
        end else begin
            fill_q <= STAGES'({fill_q, 1'b1});
        end
    end

    assign valid_o = fill_q[STAGES-1];

endmodule

// File: rtl/t9990_cpu_bridge.sv
// Host-side initiator: turns asynchronous MSX I/O cycles into one clean CSR_n/CSW_n strobe
// towards the T9990, holding the host with BUS_WAIT_n until the VDP access completes.
module t9990_cpu_bridge
    import t9990_cpu_bridge_pkg::*;
#(
    parameter logic [7:0]  PORT_BASE    = 8'h60,
    parameter int unsigned STROBE_CLKS  = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned WAIT_TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       BUS_IORQ_n,
    input  logic       BUS_RD_n,
    input  logic       BUS_WR_n,
    input  logic [7:0] BUS_A,
    input  logic [7:0] BUS_DIN,
    output logic [7:0] BUS_DOUT,
    output logic       BUS_DOUT_EN,
    output logic       BUS_WAIT_n,
    output logic       CSR_n,
    output logic       CSW_n,
    output logic [3:0] MODE,
    output logic [7:0] CD_IN,
    input  logic [7:0] CD_OUT,
    input  logic       WAIT_n,
    output logic       TIMEOUT
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CLKS - 1);
    localparam logic [9:0] WAIT_LIMIT  = 10'(WAIT_TIMEOUT);
    localparam bit         TIMEOUT_EN  = (WAIT_TIMEOUT != 0);

    logic [2:0] ctl_s;
    logic       iorq_s, rd_s, wr_s, sync_valid;

    t9990_bridge_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET_n),
        .d_i     ({BUS_IORQ_n, BUS_RD_n, BUS_WR_n}),
        .q_o     (ctl_s),
        .valid_o (sync_valid)
    );

    assign iorq_s = ctl_s[2];
    assign rd_s   = ctl_s[1];
    assign wr_s   = ctl_s[0];

    bridge_state_e state_q, state_d;
    logic          dir_rd_q, dir_rd_d;
    logic [3:0]    mode_q, mode_d;
    logic [7:0]    cd_in_q, cd_in_d;
    logic [7:0]    dout_q, dout_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    wcnt_q, wcnt_d;
    logic          csr_n_q, csr_n_d;
    logic          csw_n_q, csw_n_d;
    logic          timeout_q, timeout_d;
    logic          armed_q, armed_d;

    logic       sel, accept_rd, accept_wr, cnt_done, timeout_hit;
    logic [9:0] wait_inc;

    // armed_q blocks a host cycle that was already in progress across reset.
    assign sel       = !iorq_s && (BUS_A[7:4] == PORT_BASE[7:4]);
    assign accept_rd = (state_q == IDLE) && armed_q && sel && !rd_s && wr_s;
    assign accept_wr = (state_q == IDLE) && armed_q && sel && !wr_s && rd_s;
    assign cnt_done  = (cnt_q >= STROBE_LAST);
    assign wait_inc  = (wcnt_q == 10'h3FF) ? wcnt_q : wcnt_q + 10'd1;
    assign timeout_hit = TIMEOUT_EN && (wait_inc >= WAIT_LIMIT);

    always_comb begin
        state_d   = state_q;
        dir_rd_d  = dir_rd_q;
        mode_d    = mode_q;
        cd_in_d   = cd_in_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        timeout_d = 1'b0;
        armed_d   = armed_q | (iorq_s & sync_valid);

        unique case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    mode_d   = BUS_A[3:0];
                    dir_rd_d = 1'b1;
                    state_d  = SETUP;
                end else if (accept_wr) begin
                    mode_d   = BUS_A[3:0];
                    cd_in_d  = BUS_DIN;
                    dir_rd_d = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                wcnt_d  = 10'd0;
                state_d = STROBE;
            end
            STROBE: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (!WAIT_n) begin
                    wcnt_d = wait_inc;
                end
                // The minimum width is always honoured, even when the host has gone away.
                if (cnt_done && (WAIT_n || timeout_hit)) begin
                    state_d   = DONE;
                    timeout_d = !WAIT_n;
                    if (dir_rd_q) begin
                        dout_d = CD_OUT;
                    end
                end
            end
            DONE: begin
                if (iorq_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        csr_n_d = !((state_d == STROBE) &&  dir_rd_d);
        csw_n_d = !((state_d == STROBE) && !dir_rd_d);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            dir_rd_q  <= 1'b0;
            mode_q    <= 4'd0;
            cd_in_q   <= 8'd0;
            dout_q    <= 8'd0;
            cnt_q     <= 4'd0;
            wcnt_q    <= 10'd0;
            csr_n_q   <= 1'b1;
            csw_n_q   <= 1'b1;
            timeout_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_rd_q  <= dir_rd_d;
            mode_q    <= mode_d;
            cd_in_q   <= cd_in_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            csr_n_q   <= csr_n_d;
            csw_n_q   <= csw_n_d;
            timeout_q <= timeout_d;
            armed_q   <= armed_d;
        end
    end

    assign CSR_n       = csr_n_q;
    assign CSW_n       = csw_n_q;
    assign MODE        = mode_q;
    assign CD_IN       = cd_in_q;
    assign BUS_DOUT    = dout_q;
    assign TIMEOUT     = timeout_q;
    assign BUS_WAIT_n  = !(accept_rd || accept_wr || (state_q == SETUP) || (state_q == STROBE));
    assign BUS_DOUT_EN = (state_q == DONE) && dir_rd_q && !rd_s && !iorq_s;

endmodule

// File: tb/tb_t9990_cpu_bridge.sv
// Directed and randomised host cycles against two bridges (default and 16-cycle wait timeout)
// sharing one host bus and one VDP WAIT_n line.
module tb_t9990_cpu_bridge;
    import t9990_cpu_bridge_pkg::*;

    localparam int STROBE_CLKS = 4;
    localparam int TO_LIMIT    = 16;

    logic       CLK        = 1'b0;
    logic       RESET_n    = 1'b0;
    logic       BUS_IORQ_n = 1'b1;
    logic       BUS_RD_n   = 1'b1;
    logic       BUS_WR_n   = 1'b1;
    logic [7:0] BUS_A      = 8'h00;
    logic [7:0] BUS_DIN    = 8'h00;
    logic [7:0] CD_OUT     = 8'h00;
    logic       WAIT_n     = 1'b1;

    logic [7:0] BUS_DOUT, dout_t;
    logic       BUS_DOUT_EN, dout_en_t;
    logic       BUS_WAIT_n, bw_t;
    logic       CSR_n, csr_t;
    logic       CSW_n, csw_t;
    logic [3:0] MODE, mode_t;
    logic [7:0] CD_IN, cdin_t;
    logic       TIMEOUT, to_t;

    int checks = 0;
    int errors = 0;

    // Reference state: what the host should see from the last completed accesses.
    logic [3:0] m_mode = 4'd0;
    logic [7:0] m_cdin = 8'd0;
    logic [7:0] m_dout = 8'd0;

    always #5 CLK = ~CLK;

    t9990_cpu_bridge #(.STROBE_CLKS(STROBE_CLKS)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .BUS_IORQ_n(BUS_IORQ_n), .BUS_RD_n(BUS_RD_n),
        .BUS_WR_n(BUS_WR_n), .BUS_A(BUS_A), .BUS_DIN(BUS_DIN), .BUS_DOUT(BUS_DOUT),
        .BUS_DOUT_EN(BUS_DOUT_EN), .BUS_WAIT_n(BUS_WAIT_n), .CSR_n(CSR_n), .CSW_n(CSW_n),
        .MODE(MODE), .CD_IN(CD_IN), .CD_OUT(CD_OUT), .WAIT_n(WAIT_n), .TIMEOUT(TIMEOUT)
    );

    t9990_cpu_bridge #(.STROBE_CLKS(STROBE_CLKS), .WAIT_TIMEOUT(TO_LIMIT)) dut_to (
        .CLK(CLK), .RESET_n(RESET_n), .BUS_IORQ_n(BUS_IORQ_n), .BUS_RD_n(BUS_RD_n),
        .BUS_WR_n(BUS_WR_n), .BUS_A(BUS_A), .BUS_DIN(BUS_DIN), .BUS_DOUT(dout_t),
        .BUS_DOUT_EN(dout_en_t), .BUS_WAIT_n(bw_t), .CSR_n(csr_t), .CSW_n(csw_t),
        .MODE(mode_t), .CD_IN(cdin_t), .CD_OUT(CD_OUT), .WAIT_n(WAIT_n), .TIMEOUT(to_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = write, 1 = read, 2 = RD_n and WR_n both low.
    // wlen: VDP holds WAIT_n low for this many cycles from the first strobe-low cycle.
    task automatic do_txn(input logic [7:0] port, input int kind, input logic [7:0] wdata,
                          input logic [7:0] rdata, input int wlen, input bit abort, input int extra);
        bit         sel, exp_to;
        int         exp_w, exp_wt, hold, total;
        int         a_cyc, s_cyc, bw_lo, bw_lo_t, rd_lo, wr_lo, falls, lo_t, to_d, to_n, wrem;
        logic       prev_r, prev_w, en_seen;
        logic [3:0] mode_seen;
        logic [7:0] cdin_seen;

        sel    = (port[7:4] == 4'h6) && (kind != 2);
        exp_w  = (wlen + 1 > STROBE_CLKS) ? wlen + 1 : STROBE_CLKS;
        exp_to = (wlen >= TO_LIMIT);
        exp_wt = exp_to ? ((TO_LIMIT > STROBE_CLKS) ? TO_LIMIT : STROBE_CLKS) : exp_w;
        hold   = abort ? 4 : exp_w + 8 + extra;
        total  = hold + 16;
        a_cyc = -1; s_cyc = -1; bw_lo = 0; bw_lo_t = 0; rd_lo = 0; wr_lo = 0;
        falls = 0; lo_t = 0; to_d = 0; to_n = 0; wrem = 0;
        prev_r = 1'b1; prev_w = 1'b1; en_seen = 1'b0; mode_seen = 4'd0; cdin_seen = 8'd0;

        @(negedge CLK);
        BUS_A      = port;
        BUS_DIN    = wdata;
        CD_OUT     = rdata;
        BUS_IORQ_n = 1'b0;
        BUS_RD_n   = !(kind == 1 || kind == 2);
        BUS_WR_n   = !(kind == 0 || kind == 2);

        for (int c = 0; c < total; c++) begin
            @(negedge CLK);
            if (!BUS_WAIT_n) begin
                if (a_cyc < 0) begin
                    a_cyc = c;
                    wrem  = (wlen > 0) ? wlen + 2 : 0;
                end
                bw_lo++;
            end
            if (!bw_t) bw_lo_t++;
            if (!CSR_n) rd_lo++;
            if (!CSW_n) wr_lo++;
            if ((prev_r && !CSR_n) || (prev_w && !CSW_n)) falls++;
            if ((!CSR_n || !CSW_n) && s_cyc < 0) begin
                s_cyc     = c;
                mode_seen = MODE;
                cdin_seen = CD_IN;
            end
            prev_r = CSR_n;
            prev_w = CSW_n;
            if (!csr_t || !csw_t) lo_t++;
            if (TIMEOUT) to_d++;
            if (to_t) to_n++;
            if (c == hold - 1) begin
                en_seen    = BUS_DOUT_EN;
                BUS_IORQ_n = 1'b1;
                BUS_RD_n   = 1'b1;
                BUS_WR_n   = 1'b1;
            end
            if (wrem > 0) begin
                WAIT_n = 1'b0;
                wrem--;
            end else begin
                WAIT_n = 1'b1;
            end
        end

        if (sel) begin
            m_mode = port[3:0];
            if (kind == 0) m_cdin = wdata;
            else           m_dout = rdata;
        end

        check("bus_wait_low_cycles", bw_lo, sel ? exp_w + 2 : 0);
        check("bus_wait_low_cycles_to", bw_lo_t, sel ? exp_wt + 2 : 0);
        check("csr_low_cycles", rd_lo, (sel && kind == 1) ? exp_w : 0);
        check("csw_low_cycles", wr_lo, (sel && kind == 0) ? exp_w : 0);
        check("strobe_count", falls, sel ? 1 : 0);
        check("strobe_low_cycles_to", lo_t, sel ? exp_wt : 0);
        check("timeout_pulses", to_d, 0);
        check("timeout_pulses_to", to_n, (sel && exp_to) ? 1 : 0);
        if (sel) begin
            check("accept_to_strobe", s_cyc - a_cyc, 2);
            check("mode_at_strobe", mode_seen, port[3:0]);
            if (kind == 0) check("cd_in_at_strobe", cdin_seen, wdata);
            if (kind == 1 && !abort) check("dout_en_while_rd", en_seen, 1);
        end
        check("mode", MODE, m_mode);
        check("mode_to", mode_t, m_mode);
        check("cd_in", CD_IN, m_cdin);
        check("cd_in_to", cdin_t, m_cdin);
        check("dout", BUS_DOUT, m_dout);
        check("dout_to", dout_t, m_dout);
        check("dout_en_idle", BUS_DOUT_EN, 0);
        check("dout_en_idle_to", dout_en_t, 0);
        $display("txn port=%02h kind=%0d wdata=%02h rdata=%02h wait=%0d abort=%0d width=%0d width_to=%0d",
                 port, kind, wdata, rdata, wlen, abort, exp_w, exp_wt);
    endtask

    initial begin
        bit seen;
        int lo;

        repeat (4) @(negedge CLK);
        check("reset_csr_n", CSR_n, 1);
        check("reset_csw_n", CSW_n, 1);
        check("reset_mode", MODE, 0);
        check("reset_cd_in", CD_IN, 0);
        check("reset_dout", BUS_DOUT, 0);
        check("reset_dout_en", BUS_DOUT_EN, 0);
        check("reset_bus_wait_n", BUS_WAIT_n, 1);
        check("reset_timeout", TIMEOUT, 0);
        RESET_n = 1'b1;
        repeat (6) @(negedge CLK);

        do_txn({4'h6, P3_REG},    0, 8'hA5, 8'h00, 0,  1'b0, 4);
        do_txn({4'h6, P5_STATUS}, 1, 8'h00, 8'h3C, 0,  1'b0, 38);
        do_txn({4'h6, P1_PAL},    0, 8'h77, 8'h00, 20, 1'b0, 2);
        do_txn(8'h73,             0, 8'h99, 8'h00, 0,  1'b0, 4);
        do_txn({4'h6, P0_VRAM},   2, 8'h55, 8'h11, 0,  1'b0, 4);
        do_txn(8'h64,             0, 8'hC3, 8'h00, 60, 1'b0, 2);
        do_txn({4'h6, P4_REGSEL}, 0, 8'h12, 8'h00, 0,  1'b1, 0);
        do_txn(8'h6F,             1, 8'h00, 8'hE7, 15, 1'b0, 3);
        do_txn(8'h62,             1, 8'h00, 8'h81, 16, 1'b0, 3);

        for (int i = 0; i < 30; i++) begin
            int         r, kind, wlen;
            bit         abort;
            logic [3:0] hi;
            r     = $urandom_range(0, 9);
            kind  = (r <= 3) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : $urandom_range(0, 1);
            hi    = 4'h6;
            if (r == 9) begin
                hi = 4'($urandom_range(0, 14));
                if (hi >= 4'h6) hi = hi + 4'h1;
            end
            abort = ($urandom_range(0, 5) == 0);
            wlen  = (!abort && $urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
            do_txn({hi, 4'($urandom_range(0, 15))}, kind, 8'($urandom), 8'($urandom),
                   wlen, abort, $urandom_range(0, 20));
        end

        // Reset in the middle of a write strobe.
        @(negedge CLK);
        BUS_A      = {4'h6, P2_CMD};
        BUS_DIN    = 8'h5A;
        BUS_IORQ_n = 1'b0;
        BUS_WR_n   = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge CLK);
            if (!CSW_n) seen = 1'b1;
        end
        check("strobe_before_reset", seen, 1);
        #2 RESET_n = 1'b0;
        #1;
        check("async_reset_csw_n", CSW_n, 1);
        check("async_reset_csw_n_to", csw_t, 1);
        check("async_reset_bus_wait_n", BUS_WAIT_n, 1);
        check("async_reset_mode", MODE, 0);
        check("async_reset_cd_in", CD_IN, 0);
        m_mode = 4'd0;
        m_cdin = 8'd0;
        m_dout = 8'd0;
        @(negedge CLK);
        RESET_n = 1'b1;
        lo = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            if (!CSW_n || !CSR_n || !BUS_WAIT_n || !csw_t || !csr_t || !bw_t) lo++;
        end
        check("no_strobe_after_reset", lo, 0);
        BUS_IORQ_n = 1'b1;
        BUS_WR_n   = 1'b1;
        repeat (4) @(negedge CLK);
        do_txn({4'h6, P2_CMD}, 0, 8'h3E, 8'h00, 0, 1'b0, 1);
        do_txn({4'h6, P0_VRAM}, 1, 8'h00, 8'hD2, 2, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t9990_cpu_bridge.md
Name: t9990_cpu_bridge

Overview:
- Host-side initiator for the T9990 CPU port interface.
- Converts asynchronous MSX cartridge I/O cycles (IORQ_n/RD_n/WR_n/A/D) into single, clean CSR_n/CSW_n strobes with MODE and CD_IN, and latches CD_OUT for reads.
- Holds the host bus with BUS_WAIT_n while the VDP asserts WAIT_n.
- Sits between the cartridge edge logic and the T9990 top.

Parameters:
- PORT_BASE, 8'h60, I/O base address; A[7:4] must equal PORT_BASE[7:4] to select the VDP.
- STROBE_CLKS, 4, minimum CLK cycles CSR_n/CSW_n stay low (valid range 1..15).
- SYNC_STAGES, 2, synchroniser depth for IORQ_n/RD_n/WR_n.
- WAIT_TIMEOUT, 1023, max CLK cycles to hold a strobe while WAIT_n is low; 0 disables the timeout.

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- BUS_IORQ_n  in  1  host I/O request, asynchronous
- BUS_RD_n  in  1  host read, asynchronous
- BUS_WR_n  in  1  host write, asynchronous
- BUS_A  in  8  host I/O address
- BUS_DIN  in  8  host write data
- BUS_DOUT  out  8  read data to host
- BUS_DOUT_EN  out  1  host data bus drive enable
- BUS_WAIT_n  out  1  host wait request
- CSR_n  out  1  VDP read strobe
- CSW_n  out  1  VDP write strobe
- MODE  out  4  VDP port number (BUS_A[3:0])
- CD_IN  out  8  write data to VDP
- CD_OUT  in  8  read data from VDP
- WAIT_n  in  1  VDP wait, synchronous to CLK
- TIMEOUT  out  1  one-cycle pulse when a strobe is force-ended by the timeout

Behaviour:
- Reset (async) sets CSR_n=1, CSW_n=1, MODE=0, CD_IN=0, BUS_DOUT=0, BUS_DOUT_EN=0, BUS_WAIT_n=1, TIMEOUT=0, and the FSM to IDLE.
- Reset asserted mid-operation releases both strobes immediately; no partial strobe follows reset release.
- Synchronise IORQ_n/RD_n/WR_n through SYNC_STAGES flops. Define sel = !iorq_s && (BUS_A[7:4]==PORT_BASE[7:4]).
- BUS_A and BUS_DIN are sampled only in IDLE when the cycle is accepted; they are assumed stable during the host cycle.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - sel && !rd_s && wr_s: latch MODE=A[3:0], dir=read; go to SETUP.
  - sel && !wr_s && rd_s: latch MODE and CD_IN=BUS_DIN, dir=write; go to SETUP.
  - sel with rd_s and wr_s both low: ignored, no strobe; stay in IDLE.
  - Not selected: stay in IDLE.
  - BUS_WAIT_n goes 0 in the same cycle a cycle is accepted.
- SETUP: exactly 1 cycle with MODE/CD_IN stable and strobes high, then go to STROBE.
- STROBE:
  - Drive CSR_n (read) or CSW_n (write) low, and run a strobe counter cnt from 0.
  - Leave when cnt >= STROBE_CLKS-1 and WAIT_n=1.
  - While WAIT_n=0 the strobe stays low and BUS_WAIT_n stays 0.
  - Timeout: if WAIT_TIMEOUT!=0 and the wait counter reaches WAIT_TIMEOUT, force the exit and pulse TIMEOUT for 1 cycle.
  - On read exit: BUS_DOUT<=CD_OUT, sampled in the last strobe-low cycle.
  - On exit: strobe returns high and BUS_WAIT_n=1 on the next cycle; go to DONE.
- DONE:
  - For reads, BUS_DOUT_EN=1 while rd_s=0.
  - Return to IDLE when iorq_s=1; BUS_DOUT_EN clears in the same cycle.
  - This guarantees exactly one VDP strobe per host cycle.
- Abort: if iorq_s rises in SETUP or STROBE before the minimum width, the strobe still completes its full STROBE_CLKS (the VDP must not see a runt pulse); then DONE, then IDLE immediately.
- Strobe spacing: at least 1 cycle high between consecutive strobes, guaranteed by SETUP.
- Minimum latency, accept to strobe low: 2 CLK (1 IDLE→SETUP, 1 SETUP→STROBE).
- Counters: strobe counter is 4 bits; wait counter is 10 bits, saturating, no wrap.

Decomposition:
- Package T9990_BRIDGE holds:
  - state enum typedef (IDLE/SETUP/STROBE/DONE);
  - localparams for port numbers P0_VRAM=0, P1_PAL=1, P2_CMD=2, P3_REG=3, P4_REGSEL=4, P5_STATUS=5.
- One natural sub-module: t9990_bridge_sync, an N-stage synchroniser for the 3 control lines with async reset to 1.

Test Plan:
- Write 8'hA5 to port 8'h63 (STROBE_CLKS=4, WAIT_n=1) -> MODE=3, CD_IN=A5; CSW_n low exactly 4 cycles starting 2 cycles after accept; CSR_n stays 1; BUS_WAIT_n low for 6 cycles.
- Read port 8'h65 with CD_OUT=8'h3C -> CSR_n low 4 cycles; BUS_DOUT=3C and BUS_DOUT_EN=1 until IORQ_n rises; single strobe even though RD_n is held 50 cycles.
- Write with WAIT_n held low 20 cycles starting at strobe cycle 1 -> CSW_n low 21 cycles; BUS_WAIT_n released the cycle after WAIT_n rises.
- Access to 8'h73 (outside PORT_BASE), and a cycle with both RD_n and WR_n low at 8'h60 -> no strobe, BUS_WAIT_n stays 1.
- WAIT_TIMEOUT=16 with WAIT_n stuck low -> TIMEOUT pulses once; strobe ends after 16 wait cycles; FSM returns to IDLE once IORQ_n rises.
- RESET_n asserted during STROBE of a write -> CSW_n=1 and BUS_WAIT_n=1 asynchronously; after release with IORQ_n still low, no strobe until a new cycle begins.
